// File: rtl/msg_load_sched_ctrl.sv
// Sequencer for the LDPC encoder stored-message buffer: loads Zc-wide message
// segments column by column, then walks the multiply-shift select phases.
module msg_load_sched_ctrl #(
    parameter int unsigned MUL_SH_BLOCKS_COUNT = 4,
    parameter int unsigned BG1_MSG_COLS        = 22,
    parameter int unsigned BG2_MSG_COLS        = 10,
    parameter int unsigned SEL_PHASES          = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                BG,
    input  logic                                seg_valid,
    output logic                                seg_ready,
    output logic                                new_seg_msg_block,
    output logic [4:0]                          current_col,
    output logic [MUL_SH_BLOCKS_COUNT-1:0][1:0] stored_msg_selects,
    output logic                                sel_valid,
    output logic                                sel_first,
    output logic                                sel_last,
    input  logic                                acc_ready,
    output logic                                busy,
    output logic                                done
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSelect,
        StDone
    } state_e;

    // BG encoding: 0 = BG1, 1 = BG2.
    localparam logic       Bg1        = 1'b0;
    localparam logic [4:0] LastColBg1 = 5'(BG1_MSG_COLS - 1);
    localparam logic [4:0] LastColBg2 = 5'(BG2_MSG_COLS - 1);
    localparam logic [1:0] LastPhase  = 2'(SEL_PHASES - 1);

    state_e     state_q, state_d;
    logic       bg_q, bg_d;
    logic [4:0] col_q, col_d;
    logic [1:0] phase_q, phase_d;

    logic seg_ready_q, seg_ready_d;
    logic sel_valid_q, sel_valid_d;
    logic sel_first_q, sel_first_d;
    logic sel_last_q, sel_last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic       beat;
    logic       phase_ack;
    logic [4:0] last_col;

    assign beat      = seg_valid & seg_ready_q;
    assign phase_ack = sel_valid_q & acc_ready;
    assign last_col  = (bg_q == Bg1) ? LastColBg1 : LastColBg2;

    always_comb begin
        state_d = state_q;
        bg_d    = bg_q;
        col_d   = col_q;
        phase_d = phase_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bg_d    = BG;
                    col_d   = 5'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (beat) begin
                    // The column counter parks on the last column so current_col
                    // never reports a column beyond the message width.
                    if (col_q == last_col) begin
                        phase_d = 2'd0;
                        state_d = StSelect;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            StSelect: begin
                if (phase_ack) begin
                    if (phase_q == LastPhase) begin
                        state_d = StDone;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        seg_ready_d = (state_d == StLoad);
        sel_valid_d = (state_d == StSelect);
        sel_first_d = (state_d == StSelect) && (phase_d == 2'd0);
        sel_last_d  = (state_d == StSelect) && (phase_d == LastPhase);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bg_q        <= Bg1;
            col_q       <= 5'd0;
            phase_q     <= 2'd0;
            seg_ready_q <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_first_q <= 1'b0;
            sel_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bg_q        <= bg_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            seg_ready_q <= seg_ready_d;
            sel_valid_q <= sel_valid_d;
            sel_first_q <= sel_first_d;
            sel_last_q  <= sel_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Every multiply-shift block sees the same phase; the value holds outside SELECT.
    always_comb begin
        for (int i = 0; i < int'(MUL_SH_BLOCKS_COUNT); i++) begin
            stored_msg_selects[i] = phase_q;
        end
    end

    assign seg_ready         = seg_ready_q;
    assign new_seg_msg_block = beat;
    assign current_col       = col_q;
    assign sel_valid         = sel_valid_q;
    assign sel_first         = sel_first_q;
    assign sel_last          = sel_last_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_msg_load_sched_ctrl.sv
// Bench for msg_load_sched_ctrl: a table of codeword scenarios plus hand-written
// reset and back-to-back sequences, checked through column/phase scoreboards.
module tb_msg_load_sched_ctrl;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            BG;
    logic            seg_valid;
    logic            seg_ready;
    logic            new_seg_msg_block;
    logic [4:0]      current_col;
    logic [3:0][1:0] stored_msg_selects;
    logic            sel_valid;
    logic            sel_first;
    logic            sel_last;
    logic            acc_ready;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    msg_load_sched_ctrl #(
        .MUL_SH_BLOCKS_COUNT(4),
        .BG1_MSG_COLS       (22),
        .BG2_MSG_COLS       (10),
        .SEL_PHASES         (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .BG                (BG),
        .seg_valid         (seg_valid),
        .seg_ready         (seg_ready),
        .new_seg_msg_block (new_seg_msg_block),
        .current_col       (current_col),
        .stored_msg_selects(stored_msg_selects),
        .sel_valid         (sel_valid),
        .sel_first         (sel_first),
        .sel_last          (sel_last),
        .acc_ready         (acc_ready),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        int col;
        bit last;
    } col_exp_t;

    typedef struct {
        logic bg;
        bit   gap;
        bit   noise;
        int   stall_phase;
        int   stall_len;
        int   exp_cycles;
    } vec_t;

    col_exp_t exp_cols[$];
    int       exp_ph[$];
    int       done_cycs[$];
    int       exp_done;
    int       n_checks;
    int       n_pass;
    int       cyc;
    int       strobes;
    bit       last_beat_prev;
    vec_t     vecs[6];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Sampled mid-cycle: registered outputs and the combinational strobe are settled.
    task automatic monitor();
        col_exp_t ce;
        int       ep;
        cyc++;
        if (last_beat_prev) check("ready_drop_after_last", int'(seg_ready), 0);
        last_beat_prev = 1'b0;
        if (new_seg_msg_block) begin
            strobes++;
            if (exp_cols.size() == 0) begin
                check("spurious_strobe", int'(new_seg_msg_block), 0);
            end else begin
                ce = exp_cols.pop_front();
                check("current_col", int'(current_col), ce.col);
                last_beat_prev = ce.last;
            end
        end
        if (sel_valid) begin
            if (exp_ph.size() == 0) begin
                check("spurious_sel_valid", int'(sel_valid), 0);
            end else begin
                ep = exp_ph[0];
                for (int i = 0; i < 4; i++) check("select_copy", int'(stored_msg_selects[i]), ep);
                check("sel_first", int'(sel_first), int'(ep == 0));
                check("sel_last", int'(sel_last), int'(ep == 3));
                if (acc_ready) void'(exp_ph.pop_front());
            end
        end
        if (done) begin
            if (exp_done > 0) begin
                exp_done--;
                done_cycs.push_back(cyc);
            end else begin
                check("spurious_done", int'(done), 0);
            end
        end
    endtask

    task automatic tick();
        #5;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_codeword(input logic bg);
        int n;
        n = bg ? 10 : 22;
        for (int c = 0; c < n; c++) exp_cols.push_back('{col: c, last: (c == n - 1)});
        for (int p = 0; p < 4; p++) exp_ph.push_back(p);
        exp_done++;
    endtask

    task automatic run_cw(input vec_t v);
        int  start_cyc;
        int  stalled;
        bit  ph;
        bit  seen;
        strobes = 0;
        done_cycs.delete();
        push_codeword(v.bg);
        start     = 1'b1;
        BG        = v.bg;
        seg_valid = 1'b1;
        acc_ready = 1'b1;
        start_cyc = cyc + 1;
        tick();
        check("busy_after_start", int'(busy), 1);
        start   = 1'b0;
        ph      = 1'b1;
        stalled = 0;
        seen    = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (seg_ready) begin
                seg_valid = v.gap ? ph : 1'b1;
                ph        = ~ph;
            end else begin
                seg_valid = 1'b0;
            end
            if (v.noise) begin
                start = busy;
                BG    = ~v.bg;
            end
            if (v.stall_len > 0 && sel_valid && int'(stored_msg_selects[0]) == v.stall_phase
                && stalled < v.stall_len) begin
                acc_ready = 1'b0;
                stalled++;
            end else begin
                acc_ready = 1'b1;
            end
            tick();
            if (done_cycs.size() > 0) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("cycles_start_to_done", done_cycs[0] - start_cyc + 1, v.exp_cycles);
        end
        check("strobe_count", strobes, v.bg ? 10 : 22);
        start     = 1'b0;
        seg_valid = 1'b0;
        acc_ready = 1'b1;
        tick();
        check("idle_after_done", int'(busy), 0);
        check("cols_drained", exp_cols.size(), 0);
        check("phases_drained", exp_ph.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_seg_ready"}, int'(seg_ready), 0);
        check({tag, "_strobe"}, int'(new_seg_msg_block), 0);
        check({tag, "_current_col"}, int'(current_col), 0);
        check({tag, "_selects"}, int'(stored_msg_selects), 0);
        check({tag, "_sel_valid"}, int'(sel_valid), 0);
        check({tag, "_sel_first"}, int'(sel_first), 0);
        check({tag, "_sel_last"}, int'(sel_last), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int  c0;
        bit  hit;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        exp_done = 0;
        strobes  = 0;
        last_beat_prev = 1'b0;

        //         bg    gap   noise stall_ph stall_len cycles
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 28};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 16};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 0, 0, 25};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2, 3, 31};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 0, 1, 17};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 3, 2, 51};

        reset     = 1'b1;
        start     = 1'b0;
        BG        = 1'b0;
        seg_valid = 1'b1;
        acc_ready = 1'b1;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // seg_valid in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_ready", int'(seg_ready), 0);
            check("idle_no_strobe", int'(new_seg_msg_block), 0);
        end
        seg_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_cw(vecs[i]);

        // Reset in the middle of a BG1 load.
        push_codeword(1'b0);
        start     = 1'b1;
        BG        = 1'b0;
        seg_valid = 1'b1;
        tick();
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (current_col == 5'd7) hit = 1'b1;
            else tick();
        end
        check("reached_col7", int'(hit), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_cols.delete();
        exp_ph.delete();
        exp_done = 0;
        last_beat_prev = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        seg_valid = 1'b0;
        done_cycs.delete();
        for (int i = 0; i < 3; i++) tick();
        check("no_done_after_abort", done_cycs.size(), 0);
        run_cw(vecs[0]);

        // Back-to-back codewords with start held high.
        strobes = 0;
        done_cycs.delete();
        push_codeword(1'b1);
        push_codeword(1'b1);
        start     = 1'b1;
        BG        = 1'b1;
        seg_valid = 1'b1;
        acc_ready = 1'b1;
        c0 = cyc + 1;
        for (int k = 0; k < 100 && done_cycs.size() < 2; k++) tick();
        start = 1'b0;
        if (done_cycs.size() < 2) begin
            check("b2b_done_timeout", done_cycs.size(), 2);
        end else begin
            check("b2b_first_cycles", done_cycs[0] - c0 + 1, 16);
            check("b2b_second_cycles", done_cycs[1] - done_cycs[0], 16);
        end
        check("b2b_strobes", strobes, 20);
        seg_valid = 1'b0;
        tick();
        check("b2b_idle", int'(busy), 0);
        check("b2b_cols_drained", exp_cols.size(), 0);
        check("b2b_phases_drained", exp_ph.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
